// File: rtl/traffic_light_fsm.sv
// Tick-timed traffic light sequencer: main/side lamp phases, optional walk phase,
// and a one-cycle wr_reset pulse back to the walk request latch on walk entry.
module traffic_light_fsm #(
  parameter int T_BASE  = 6,
  parameter int T_EXT   = 3,
  parameter int T_YEL   = 2,
  parameter int T_WALK  = 3,
  parameter int TIMER_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       wr,
  input  logic       sensor_sync,
  output logic       wr_reset,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_lamp,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    MAIN_G1  = 3'd0,
    MAIN_G2  = 3'd1,
    MAIN_Y   = 3'd2,
    WALK     = 3'd3,
    SIDE_G   = 3'd4,
    SIDE_EXT = 3'd5,
    SIDE_Y   = 3'd6
  } state_e;

  localparam logic [TIMER_W-1:0] C_BASE = TIMER_W'(T_BASE);
  localparam logic [TIMER_W-1:0] C_EXT  = TIMER_W'(T_EXT);
  localparam logic [TIMER_W-1:0] C_YEL  = TIMER_W'(T_YEL);
  localparam logic [TIMER_W-1:0] C_WALK = TIMER_W'(T_WALK);
  localparam logic [TIMER_W-1:0] C_ONE  = TIMER_W'(1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   cnt_q, cnt_d;
  logic                 wr_reset_d;
  logic                 expire;

  // Lamp word {main[2:0], side[2:0], walk}; lamps are {R,Y,G}.
  function automatic logic [6:0] lamps(input state_e s);
    case (s)
      MAIN_G1, MAIN_G2: lamps = 7'b001_100_0;
      MAIN_Y:           lamps = 7'b010_100_0;
      WALK:             lamps = 7'b100_100_1;
      SIDE_G, SIDE_EXT: lamps = 7'b100_001_0;
      SIDE_Y:           lamps = 7'b100_010_0;
      default:          lamps = 7'b001_100_0;
    endcase
  endfunction

  assign expire    = tick && (cnt_q == C_ONE);
  assign state_dbg = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_reset_d = 1'b0;
    if (tick && (cnt_q != C_ONE)) cnt_d = cnt_q - C_ONE;
    case (state_q)
      MAIN_G1: if (expire) begin
        state_d = MAIN_G2;
        cnt_d   = sensor_sync ? C_EXT : C_BASE;
      end
      MAIN_G2: if (expire) begin
        state_d = MAIN_Y;
        cnt_d   = C_YEL;
      end
      MAIN_Y: if (expire) begin
        if (wr) begin
          state_d    = WALK;
          cnt_d      = C_WALK;
          wr_reset_d = 1'b1;
        end else begin
          state_d = SIDE_G;
          cnt_d   = C_BASE;
        end
      end
      WALK: if (expire) begin
        state_d = SIDE_G;
        cnt_d   = C_BASE;
      end
      SIDE_G: if (expire) begin
        state_d = sensor_sync ? SIDE_EXT : SIDE_Y;
        cnt_d   = sensor_sync ? C_EXT : C_YEL;
      end
      SIDE_EXT: if (expire) begin
        state_d = SIDE_Y;
        cnt_d   = C_YEL;
      end
      SIDE_Y: if (expire) begin
        state_d = MAIN_G1;
        cnt_d   = C_BASE;
      end
      // Unused encoding recovers on the next edge regardless of tick.
      default: begin
        state_d = MAIN_G1;
        cnt_d   = C_BASE;
      end
    endcase
  end

  // Lamps are registered from the next state so they always match state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MAIN_G1;
      cnt_q      <= C_BASE;
      wr_reset   <= 1'b0;
      main_light <= 3'b001;
      side_light <= 3'b100;
      walk_lamp  <= 1'b0;
    end else begin
      state_q                            <= state_d;
      cnt_q                              <= cnt_d;
      wr_reset                           <= wr_reset_d;
      {main_light, side_light, walk_lamp} <= lamps(state_d);
    end
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: vector table, directed multi-cycle sequences and
// randomized traffic checked against a phase/duration schedule model.
module tb_traffic_light_fsm;

  localparam int T_BASE = 6;
  localparam int T_EXT  = 3;
  localparam int T_YEL  = 2;
  localparam int T_WALK = 3;

  // Output word {main, side, walk, wr_reset}.
  localparam logic [7:0] O_MG  = 8'b001_100_0_0;
  localparam logic [7:0] O_MY  = 8'b010_100_0_0;
  localparam logic [7:0] O_WE  = 8'b100_100_1_1;
  localparam logic [7:0] O_WK  = 8'b100_100_1_0;
  localparam logic [7:0] O_SG  = 8'b100_001_0_0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       wr = 1'b0;
  logic       sensor_sync = 1'b0;
  logic       wr_reset;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_lamp;
  logic [2:0] state_dbg;

  int checks = 0;
  int passed = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  traffic_light_fsm #(
    .T_BASE(T_BASE), .T_EXT(T_EXT), .T_YEL(T_YEL), .T_WALK(T_WALK), .TIMER_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .wr(wr), .sensor_sync(sensor_sync),
    .wr_reset(wr_reset), .main_light(main_light), .side_light(side_light),
    .walk_lamp(walk_lamp), .state_dbg(state_dbg)
  );

  // ---------------- reference model: phase index + ticks remaining ----------------
  // Phases: 0 main green (first half), 1 main green (second half), 2 main yellow,
  // 3 walk, 4 side green, 5 side extension, 6 side yellow.
  int   m_ph;
  int   m_rem;
  logic m_wrr;

  task automatic model_reset();
    m_ph  = 0;
    m_rem = T_BASE;
    m_wrr = 1'b0;
  endtask

  task automatic model_edge(input logic t, input logic w, input logic s);
    m_wrr = 1'b0;
    if (!t) return;
    if (m_rem > 1) begin
      m_rem = m_rem - 1;
      return;
    end
    case (m_ph)
      0: begin m_ph = 1; m_rem = s ? T_EXT : T_BASE; end
      1: begin m_ph = 2; m_rem = T_YEL; end
      2: if (w) begin m_ph = 3; m_rem = T_WALK; m_wrr = 1'b1; end
         else   begin m_ph = 4; m_rem = T_BASE; end
      3: begin m_ph = 4; m_rem = T_BASE; end
      4: if (s) begin m_ph = 5; m_rem = T_EXT; end
         else   begin m_ph = 6; m_rem = T_YEL; end
      5: begin m_ph = 6; m_rem = T_YEL; end
      default: begin m_ph = 0; m_rem = T_BASE; end
    endcase
  endtask

  function automatic logic [7:0] model_out();
    logic [6:0] l;
    case (m_ph)
      0, 1:    l = 7'b001_100_0;
      2:       l = 7'b010_100_0;
      3:       l = 7'b100_100_1;
      4, 5:    l = 7'b100_001_0;
      default: l = 7'b100_010_0;
    endcase
    return {l, m_wrr};
  endfunction

  // ---------------- scoreboard ----------------
  function automatic logic [7:0] dut_out();
    return {main_light, side_light, walk_lamp, wr_reset};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic cycle(input logic r, input logic t, input logic w, input logic s);
    rst_n = r; tick = t; wr = w; sensor_sync = s;
    @(posedge clk);
    if (!r) model_reset();
    else model_edge(t, w, s);
    #1;
    check("model", dut_out(), model_out());
    check("no_conflict", {7'b0, main_light[0] & side_light[0]}, 8'h00);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick = 1'b0; wr = 1'b0; sensor_sync = 1'b0;
    @(posedge clk);
    #1;
    check("reset_state", dut_out(), O_MG);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Counts per lamp pattern over n cycles with fixed wr/sensor; tick every tdiv cycles.
  int c_mg, c_my, c_sg, c_sy, c_walk, c_wrr;
  task automatic run_count(input int n, input int tdiv, input logic w, input logic s);
    c_mg = 0; c_my = 0; c_sg = 0; c_sy = 0; c_walk = 0; c_wrr = 0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, (i % tdiv) == 0, w, s);
      if (main_light == 3'b001) c_mg++;
      if (main_light == 3'b010) c_my++;
      if (side_light == 3'b001) c_sg++;
      if (side_light == 3'b010) c_sy++;
      if (walk_lamp) c_walk++;
      if (wr_reset) c_wrr++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       t;
    logic       w;
    logic       s;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // Walk round with sensor high: G1 6 ticks, G2 shortened to 3, yellow 2, walk 3.
    tbl[0]  = '{1'b0, 1'b1, 1'b1, O_MG};
    for (int i = 1; i <= 8; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, O_MG};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, O_MY};
    tbl[10] = '{1'b1, 1'b1, 1'b1, O_MY};
    tbl[11] = '{1'b1, 1'b1, 1'b1, O_WE};
    tbl[12] = '{1'b0, 1'b1, 1'b1, O_WK};
    tbl[13] = '{1'b1, 1'b1, 1'b1, O_WK};
    tbl[14] = '{1'b1, 1'b1, 1'b1, O_WK};
    tbl[15] = '{1'b1, 1'b1, 1'b1, O_SG};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick = tbl[i].t; wr = tbl[i].w; sensor_sync = tbl[i].s;
      @(posedge clk);
      model_edge(tbl[i].t, tbl[i].w, tbl[i].s);
      #1;
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
      @(negedge clk);
    end
    // Walk request cleared: following rounds never walk.
    run_count(44, 1, 1'b0, 1'b0);
    check_int("no_walk_after_clear", c_walk, 0);
    check_int("no_pulse_after_clear", c_wrr, 0);

    // Defaults: 22-cycle period, 12 main green / 2 yellow / 6 side green / 2 side yellow.
    do_reset();
    run_count(44, 1, 1'b0, 1'b0);
    check_int("dflt_main_g", c_mg, 24);
    check_int("dflt_main_y", c_my, 4);
    check_int("dflt_side_g", c_sg, 12);
    check_int("dflt_side_y", c_sy, 4);
    check_int("dflt_wr_reset", c_wrr, 0);

    // Sensor held: 9 main green, 9 side green, still 22-cycle period.
    do_reset();
    run_count(44, 1, 1'b0, 1'b1);
    check_int("sens_main_g", c_mg, 18);
    check_int("sens_main_y", c_my, 4);
    check_int("sens_side_g", c_sg, 18);
    check_int("sens_side_y", c_sy, 4);

    // Tick every 4th cycle: one full period is 88 cycles, yellow lasts 8.
    do_reset();
    run_count(88, 4, 1'b0, 1'b0);
    check_int("slow_main_g", c_mg, 48);
    check_int("slow_main_y", c_my, 8);
    check_int("slow_side_g", c_sg, 24);
    check_int("slow_side_y", c_sy, 8);

    // Async reset in the middle of the wr_reset pulse.
    do_reset();
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("pulse_before_reset", dut_out(), O_WE);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_out(), O_MG);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_count(11, 1, 1'b0, 1'b0);
    check_int("g_after_reset", c_mg, 11);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("yellow_after_12", dut_out(), O_MY);

    // Request raised only during side green: served on the following round.
    do_reset();
    run_count(14, 1, 1'b0, 1'b0);
    check("side_g_entry", dut_out(), O_SG);
    run_count(8, 1, 1'b1, 1'b0);
    check_int("late_req_no_walk", c_walk, 0);
    run_count(22, 1, 1'b1, 1'b0);
    check_int("late_req_walk", c_walk, T_WALK);
    check_int("late_req_pulse", c_wrr, 1);

    // Randomized traffic with occasional resets.
    do_reset();
    begin
      logic w_hold;
      w_hold = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 9) == 0) w_hold = ~w_hold;
        cycle($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0, w_hold,
              1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
